param_calc: RTL and testbench

Parametrised successor to the single-cycle calculator: a register-file calculator with configurable data width and register count and a valid/ready instruction handshake. It decodes one 32-bit instruction per accepted transfer, executes ALU operations in one cycle and an optional iterative multiply over multiple cycles, and presents each result with a one-cycle valid strobe. It sits between the instruction source (bench or sequencer) and any result consumer.

---
 rtl/pcalc_pkg.sv | 44 ++++
 rtl/pcalc_regfile.sv | 41 ++++
 rtl/param_calc.sv | 258 +++++++++++++++++++++++++
 tb/tb_param_calc.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcalc_pkg.sv
// pcalc_pkg: shared types and constants for the param_calc register-file calculator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: opcode enumeration, instruction field positions, FSM state type,
// and the immediate extension helper.
package pcalc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LI   = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_MUL  = 4'd8,
        OP_ADDI = 4'd9,
        OP_MOV  = 4'd10
    } opcode_e;

    // Instruction field positions.
    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS_MSB  = 23;
    localparam int RS_LSB  = 20;
    localparam int IMM_MSB = 19;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    // Sign-extend the 20-bit immediate to 32 bits; callers truncate to WIDTH.
    function automatic logic [31:0] ext_imm(input logic [IMM_W-1:0] imm);
        return {{(32 - IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/pcalc_regfile.sv
// pcalc_regfile: NREGS x WIDTH register file, two combinational read ports, one write port.
// Latency: reads combinational, write takes effect at the rising edge.
// Backpressure: none; a write is accepted every cycle wr_en is high.
//
// Ports: clk, reset (async active-high, clears all registers),
//        rd_idx/rd_data and rs_idx/rs_data (read ports),
//        wr_en/wr_idx/wr_data (write port).
module pcalc_regfile
    import pcalc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    input  logic [AW-1:0]    rs_idx,
    output logic [WIDTH-1:0] rs_data,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_data
);

    logic [WIDTH-1:0] regs [NREGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    assign rd_data = regs[rd_idx];
    assign rs_data = regs[rs_idx];

endmodule

// File: rtl/param_calc.sv
// param_calc: register-file calculator with valid/ready instruction intake.
// Latency: ALU ops write at the accept edge (result_valid next cycle); MUL writes WIDTH edges after accept.
// Backpressure: inst_ready is low while a MUL iterates; otherwise one instruction per cycle.
//
// Optional feature macro: PCALC_MUL_EN (iterative shift-add multiply, MUL state, iteration counter).
// Without it opcode 8 is illegal and inst_ready is tied high.
//
// Ports: clk, reset (async active-high), inst_valid/inst_ready/instruction (intake),
//        result/result_rd/overflow (held until next completion), result_valid (1-cycle strobe),
//        illegal (1-cycle strobe for an accepted illegal opcode).
module param_calc
    import pcalc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_valid,
    output logic             inst_ready,
    input  logic [31:0]      instruction,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       result_rd,
    output logic             result_valid,
    output logic             overflow,
    output logic             illegal
);

    localparam int AW = $clog2(NREGS);
    localparam logic [5:0] WIDTH_6 = 6'(WIDTH);

    // ---------------------------------------------------------------- decode
    opcode_e          op;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    rs_idx;
    logic [31:0]      imm32;
    logic [WIDTH-1:0] imm_w;
    logic             accept;

    assign op     = opcode_e'(instruction[OP_MSB:OP_LSB]);
    assign rd_idx = instruction[RD_LSB +: AW];
    assign rs_idx = instruction[RS_LSB +: AW];
    assign imm32  = ext_imm(instruction[IMM_MSB:IMM_LSB]);
    assign imm_w  = imm32[WIDTH-1:0];
    assign accept = inst_valid & inst_ready;

    // ---------------------------------------------------------- register file
    logic [WIDTH-1:0] rd_dat;
    logic [WIDTH-1:0] rs_dat;
    logic             wr_en;
    logic [AW-1:0]    wr_idx;
    logic [WIDTH-1:0] wr_data;
    logic             wr_ovf;

    pcalc_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS),
        .AW    (AW)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rd_idx  (rd_idx),
        .rd_data (rd_dat),
        .rs_idx  (rs_idx),
        .rs_data (rs_dat),
        .wr_en   (wr_en),
        .wr_idx  (wr_idx),
        .wr_data (wr_data)
    );

    // -------------------------------------------------------------------- ALU
    logic [WIDTH-1:0] add_s;
    logic [WIDTH-1:0] sub_s;
    logic [WIDTH-1:0] addi_s;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_val;
    logic             alu_ovf;
    logic             alu_wr;
    logic             alu_ill;

    assign add_s  = rd_dat + rs_dat;
    assign sub_s  = rd_dat - rs_dat;
    assign addi_s = rd_dat + imm_w;
    assign shamt  = rs_dat[4:0];

    always_comb begin
        alu_val = '0;
        alu_ovf = 1'b0;
        alu_wr  = 1'b0;
        alu_ill = 1'b0;
        case (op)
            OP_NOP: ;
            OP_LI: begin
                alu_wr  = 1'b1;
                alu_val = imm_w;
            end
            OP_ADD: begin
                alu_wr  = 1'b1;
                alu_val = add_s;
                // Like-signed operands producing an opposite-signed sum.
                alu_ovf = (rd_dat[WIDTH-1] == rs_dat[WIDTH-1]) &&
                          (add_s[WIDTH-1] != rd_dat[WIDTH-1]);
            end
            OP_SUB: begin
                alu_wr  = 1'b1;
                alu_val = sub_s;
                // Differently-signed operands where the result sign flips from the minuend.
                alu_ovf = (rd_dat[WIDTH-1] != rs_dat[WIDTH-1]) &&
                          (sub_s[WIDTH-1] != rd_dat[WIDTH-1]);
            end
            OP_AND: begin
                alu_wr  = 1'b1;
                alu_val = rd_dat & rs_dat;
            end
            OP_OR: begin
                alu_wr  = 1'b1;
                alu_val = rd_dat | rs_dat;
            end
            OP_XOR: begin
                alu_wr  = 1'b1;
                alu_val = rd_dat ^ rs_dat;
            end
            OP_SHL: begin
                alu_wr = 1'b1;
                // Only matters for WIDTH < 32, where a 5-bit amount can exceed the word.
                if ({1'b0, shamt} >= WIDTH_6) begin
                    alu_val = '0;
                end else begin
                    alu_val = rd_dat << shamt;
                end
            end
            OP_MUL: begin
`ifdef PCALC_MUL_EN
                // Handled by the iterator; nothing written at the accept edge.
                alu_wr = 1'b0;
`else
                alu_ill = 1'b1;
`endif
            end
            OP_ADDI: begin
                alu_wr  = 1'b1;
                alu_val = addi_s;
                alu_ovf = (rd_dat[WIDTH-1] == imm_w[WIDTH-1]) &&
                          (addi_s[WIDTH-1] != rd_dat[WIDTH-1]);
            end
            OP_MOV: begin
                alu_wr  = 1'b1;
                alu_val = rs_dat;
            end
            default: alu_ill = 1'b1;
        endcase
    end

    // ---------------------------------------------------------- MUL iterator
    logic             mul_done;
    logic [AW-1:0]    mul_rd;
    logic [WIDTH-1:0] mul_val;
    logic             mul_ovf;

`ifdef PCALC_MUL_EN
    localparam int CW = $clog2(WIDTH);

    state_e             state;
    state_e             state_nxt;
    logic [CW-1:0]      cnt;
    logic               mul_last;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;

    assign mul_last = (cnt == CW'(WIDTH - 1));
    // One partial product per cycle, LSB of the multiplier first.
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            mul_rd <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && inst_valid && op == OP_MUL) begin
                // Operands are sampled at the accept edge.
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, rd_dat};
                mplier <= rs_dat;
                cnt    <= '0;
                mul_rd <= rd_idx;
            end else if (state == ST_MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= mul_last ? '0 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        inst_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                inst_ready = 1'b1;
                if (inst_valid && op == OP_MUL) begin
                    state_nxt = ST_MUL;
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign mul_done = (state == ST_MUL) && mul_last;
    assign mul_val  = acc_nxt[WIDTH-1:0];
    assign mul_ovf  = |acc_nxt[2*WIDTH-1:WIDTH];
`else
    assign inst_ready = 1'b1;
    assign mul_done   = 1'b0;
    assign mul_rd     = '0;
    assign mul_val    = '0;
    assign mul_ovf    = 1'b0;
`endif

    // ----------------------------------------------------------- write port
    // No accept can coincide with mul_done because inst_ready is low in MUL.
    assign wr_en   = (accept && alu_wr) || mul_done;
    assign wr_idx  = mul_done ? mul_rd  : rd_idx;
    assign wr_data = mul_done ? mul_val : alu_val;
    assign wr_ovf  = mul_done ? mul_ovf : alu_ovf;

    // -------------------------------------------------------- output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result       <= '0;
            result_rd    <= '0;
            result_valid <= 1'b0;
            overflow     <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            result_valid <= wr_en;
            illegal      <= accept && alu_ill;
            if (wr_en) begin
                result    <= wr_data;
                result_rd <= 4'(wr_idx);
                overflow  <= wr_ovf;
            end
        end
    end

endmodule

// File: tb/tb_param_calc.sv
// tb_param_calc: directed bench for param_calc (WIDTH=32, NREGS=16) with a reference model.
// The model predicts inst_ready, strobes and held outputs every cycle; literal checks pin it.
// Covers both builds of the multiply feature (PCALC_MUL_EN).
module tb_param_calc;

    localparam int W = 32;
`ifdef PCALC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] result;
    logic [3:0]  result_rd;
    logic        result_valid;
    logic        overflow;
    logic        illegal;

    always #5 clk = ~clk;

    param_calc #(.WIDTH(32), .NREGS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .instruction  (instruction),
        .result       (result),
        .result_rd    (result_rd),
        .result_valid (result_valid),
        .overflow     (overflow),
        .illegal      (illegal)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    typedef struct packed {
        logic        legal;
        logic        wr;
        logic        mul;
        logic [31:0] val;
        logic        ovf;
    } pred_t;

    function automatic pred_t predict(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b);
        pred_t       p;
        longint      sa;
        longint      sb;
        longint      si;
        longint      s;
        logic [63:0] prod;
        int          sh;
        p  = '0;
        p.legal = 1'b1;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        si = longint'($signed(ins[19:0]));
        s  = 0;
        case (ins[31:28])
            4'd0: ;
            4'd1: begin p.wr = 1'b1; p.val = si[31:0]; end
            4'd2: begin s = sa + sb; p.wr = 1'b1; p.val = s[31:0]; p.ovf = (s > SMAX) || (s < SMIN); end
            4'd3: begin s = sa - sb; p.wr = 1'b1; p.val = s[31:0]; p.ovf = (s > SMAX) || (s < SMIN); end
            4'd4: begin p.wr = 1'b1; p.val = a & b; end
            4'd5: begin p.wr = 1'b1; p.val = a | b; end
            4'd6: begin p.wr = 1'b1; p.val = a ^ b; end
            4'd7: begin
                sh = int'(b[4:0]);
                p.wr = 1'b1;
                p.val = (sh >= W) ? 32'd0 : (a << sh);
            end
            4'd8: begin
                if (MUL_EN) begin
                    prod  = {32'd0, a} * {32'd0, b};
                    p.mul = 1'b1;
                    p.val = prod[31:0];
                    p.ovf = (prod[63:32] != 32'd0);
                end else begin
                    p.legal = 1'b0;
                end
            end
            4'd9: begin s = sa + si; p.wr = 1'b1; p.val = s[31:0]; p.ovf = (s > SMAX) || (s < SMIN); end
            4'd10: begin p.wr = 1'b1; p.val = b; end
            default: p.legal = 1'b0;
        endcase
        return p;
    endfunction

    logic [31:0] m_regs [16];
    pred_t       m_pred;
    int          m_busy;
    logic [3:0]  m_prd;
    logic [31:0] m_pres;
    logic        m_povf;
    logic        m_ready;
    logic [31:0] exp_result;
    logic [3:0]  exp_rd;
    logic        exp_valid;
    logic        exp_ovf;
    logic        exp_ill;

    assign m_pred  = predict(instruction, m_regs[instruction[27:24]], m_regs[instruction[23:20]]);
    assign m_ready = (m_busy == 0);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] <= '0;
            m_busy     <= 0;
            m_prd      <= '0;
            m_pres     <= '0;
            m_povf     <= 1'b0;
            exp_result <= '0;
            exp_rd     <= '0;
            exp_valid  <= 1'b0;
            exp_ovf    <= 1'b0;
            exp_ill    <= 1'b0;
        end else begin
            exp_valid <= 1'b0;
            exp_ill   <= 1'b0;
            if (m_busy != 0) begin
                m_busy <= m_busy - 1;
                if (m_busy == 1) begin
                    m_regs[m_prd] <= m_pres;
                    exp_result    <= m_pres;
                    exp_rd        <= m_prd;
                    exp_ovf       <= m_povf;
                    exp_valid     <= 1'b1;
                end
            end else if (inst_valid) begin
                if (!m_pred.legal) begin
                    exp_ill <= 1'b1;
                end else if (m_pred.mul) begin
                    m_busy <= W;
                    m_prd  <= instruction[27:24];
                    m_pres <= m_pred.val;
                    m_povf <= m_pred.ovf;
                end else if (m_pred.wr) begin
                    m_regs[instruction[27:24]] <= m_pred.val;
                    exp_result <= m_pred.val;
                    exp_rd     <= instruction[27:24];
                    exp_ovf    <= m_pred.ovf;
                    exp_valid  <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------- per-cycle compare + monitor
    int cyc = 0;
    int n_rv = 0;
    int n_ill = 0;
    int n_busy_low = 0;
    int last_rv_cyc = 0;
    int acc_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("inst_ready", inst_ready, m_ready);
        check("result_valid", result_valid, exp_valid);
        check("illegal", illegal, exp_ill);
        check("result", result, exp_result);
        check("result_rd", result_rd, exp_rd);
        check("overflow", overflow, exp_ovf);
        if (result_valid) begin
            n_rv <= n_rv + 1;
            last_rv_cyc <= cyc;
        end
        if (illegal) n_ill <= n_ill + 1;
        if (!inst_ready) n_busy_low <= n_busy_low + 1;
    end

    // --------------------------------------------------------------- driver
    function automatic logic [31:0] enc(input int op, input int rd, input int rs, input logic [19:0] imm);
        return {4'(op), 4'(rd), 4'(rs), imm};
    endfunction

    task automatic send(input logic [31:0] ins);
        int guard;
        @(negedge clk);
        inst_valid  = 1'b1;
        instruction = ins;
        guard = 0;
        while (!m_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!m_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: instruction 0x%0h never accepted", ins);
            inst_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        inst_valid = 1'b0;
        repeat (n) @(negedge clk);
        #1;
    endtask

    int rv0;
    int il0;
    int bl0;
    logic [31:0] held;

    initial begin
        reset       = 1'b1;
        inst_valid  = 1'b0;
        instruction = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_ready", inst_ready, 1'b1);
        check("rst_valid", result_valid, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;

        // Load and add, back to back.
        rv0 = n_rv;
        send(enc(1, 1, 0, 20'd5));
        send(enc(1, 2, 0, 20'd7));
        send(enc(2, 1, 2, 20'd0));
        idle(3);
        check("add_strobes", n_rv - rv0, 3);
        check("add_result", result, 32'd12);
        check("add_rd", result_rd, 4'd1);
        check("add_ovf", overflow, 1'b0);

        // Sign extension of LI.
        send(enc(1, 3, 0, 20'hFFFFF));
        idle(2);
        check("li_neg", result, 32'hFFFF_FFFF);

        // Build 0x7FFFFFFF, then ADDI 1 overflows.
        send(enc(1, 4, 0, 20'h7FFFF));
        send(enc(1, 8, 0, 20'd12));
        send(enc(7, 4, 8, 20'd0));
        send(enc(1, 7, 0, 20'hFFF));
        send(enc(5, 4, 7, 20'd0));
        idle(2);
        check("max_pos", result, 32'h7FFF_FFFF);
        send(enc(9, 4, 0, 20'd1));
        idle(2);
        check("addi_ovf_result", result, 32'h8000_0000);
        check("addi_ovf_flag", overflow, 1'b1);

        // MUL 0x10000 * 0x30000.
        send(enc(1, 5, 0, 20'd1));
        send(enc(1, 9, 0, 20'd16));
        send(enc(7, 5, 9, 20'd0));
        send(enc(1, 6, 0, 20'd3));
        send(enc(7, 6, 9, 20'd0));
        idle(2);
        bl0 = n_busy_low;
        il0 = n_ill;
        send(enc(8, 5, 6, 20'd0));
        idle(40);
        if (MUL_EN) begin
            check("mul_big_result", result, 32'd0);
            check("mul_big_ovf", overflow, 1'b1);
            check("mul_big_busy", n_busy_low - bl0, 32);
            check("mul_big_latency", last_rv_cyc - acc_cyc, 32);
        end else begin
            check("nomul_illegal", n_ill - il0, 1);
            check("nomul_ready", n_busy_low - bl0, 0);
            check("nomul_held", result, 32'h0003_0000);
        end

        // MUL 6 * 7.
        send(enc(1, 10, 0, 20'd6));
        send(enc(1, 11, 0, 20'd7));
        send(enc(8, 10, 11, 20'd0));
        idle(40);
        check("mul67_result", result, MUL_EN ? 32'd42 : 32'd7);
        check("mul67_ovf", overflow, 1'b0);
        if (MUL_EN) check("mul67_latency", last_rv_cyc - acc_cyc, 32);

        // Instruction held valid across a busy MUL executes exactly once.
        rv0 = n_rv;
        send(enc(8, 10, 11, 20'd0));
        send(enc(9, 10, 0, 20'd1));
        idle(3);
        check("hold_strobes", n_rv - rv0, MUL_EN ? 2 : 1);
        check("hold_result", result, MUL_EN ? 32'd295 : 32'd7);
        held = MUL_EN ? 32'd295 : 32'd7;

        // Illegal opcode 12.
        rv0 = n_rv;
        il0 = n_ill;
        send(enc(12, 10, 11, 20'd3));
        idle(3);
        check("ill_pulses", n_ill - il0, 1);
        check("ill_no_strobe", n_rv - rv0, 0);
        check("ill_result_held", result, held);
        send(enc(10, 13, 10, 20'd0));
        idle(2);
        check("ill_regs_kept", result, held);

        // Reset during cycle 10 of a MUL.
        send(enc(1, 14, 0, 20'd9));
        send(enc(1, 15, 0, 20'd3));
        send(enc(8, 14, 15, 20'd0));
        inst_valid = 1'b0;
        repeat (9) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_result", result, 32'd0);
        check("midrst_rd", result_rd, 4'd0);
        check("midrst_valid", result_valid, 1'b0);
        check("midrst_ovf", overflow, 1'b0);
        check("midrst_ready", inst_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        rv0 = n_rv;
        send(enc(10, 1, 14, 20'd0));
        idle(2);
        check("midrst_mov", result, 32'd0);
        check("midrst_mov_rd", result_rd, 4'd1);
        send(enc(1, 2, 0, 20'h123));
        idle(2);
        check("post_rst_li", result, 32'h123);
        check("post_rst_strobes", n_rv - rv0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
